// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide over a shared hi/lo register pair, with a sign/special-case fixup step.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]      state;
    logic [4:0]      cnt;
    logic [2:0]      op;
    logic [XLEN-1:0] hi, lo, addend, rs1_q;
    logic            neg_q, neg_r, div_zero, ovf;

    logic            accept;
    logic            sgn1, sgn2, is_div;
    logic [XLEN-1:0] mag1, mag2;

    assign accept = start && (state == IDLE || state == DONE);
    assign is_div = funct3[2];
    assign sgn1   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sgn2   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign mag1   = (sgn1 && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    assign mag2   = (sgn2 && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

    // One iteration step; lo holds the multiplier or the dividend/quotient.
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [XLEN-1:0] hi_step, lo_step;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, addend};
        if (op[2]) begin
            if (!div_diff[XLEN]) begin
                hi_step = div_diff[XLEN-1:0];
                lo_step = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_step = div_sh[XLEN-1:0];
                lo_step = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_result;

    always_comb begin
        prod = neg_q ? -{hi, lo} : {hi, lo};
        quo  = neg_q ? -lo : lo;
        rem  = neg_r ? -hi : hi;
        if (div_zero) begin
            quo = '1;
            rem = rs1_q;
        end else if (ovf) begin
            quo = rs1_q;
            rem = '0;
        end
        case (op)
            3'b000:          fix_result = prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          fix_result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:  fix_result = quo;
            default:         fix_result = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            hi       <= '0;
            lo       <= '0;
            addend   <= '0;
            rs1_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            state    <= CALC;
            cnt      <= '0;
            op       <= funct3;
            hi       <= '0;
            lo       <= mag1;
            addend   <= mag2;
            rs1_q    <= rs1_data;
            neg_q    <= (sgn1 && rs1_data[XLEN-1]) ^ (sgn2 && rs2_data[XLEN-1]);
            neg_r    <= sgn1 && rs1_data[XLEN-1];
            div_zero <= is_div && (rs2_data == '0);
            ovf      <= (funct3 == 3'b100 || funct3 == 3'b110) &&
                        (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        end else begin
            case (state)
                CALC: begin
                    hi  <= hi_step;
                    lo  <= lo_step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIXUP;
                end
                FIXUP: begin
                    result <= fix_result;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC) || (state == FIXUP);
    assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random vectors against a
// behavioural model, and hand-written sequences for ignore/back-to-back/reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic        busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0] u;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (f3)
            3'b000: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
            3'b011: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drives a request (caller is away from the clock edge) and returns #1 after the accepting edge.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        start    = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start    = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        funct3   = 3'($urandom_range(0, 7));
    endtask

    // Called #1 after the accepting edge; glitch_at injects a one-edge start pulse mid-run.
    task automatic wait_done(input string name, input int glitch_at);
        int cycles = 1;
        int busy_cnt = 0;
        bit overlap = 0;
        if (busy && !done) busy_cnt++;
        while (!done && cycles < 100) begin
            if (cycles == glitch_at) begin
                start = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (busy && done) overlap = 1;
            if (busy && !done) busy_cnt++;
        end
        start = 1'b0;
        check({name, " latency"}, 32'(cycles), 32'd34);
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({name, " busy_in_done"}, {31'b0, busy | overlap}, 32'd0);
        if (!done) begin
            check({name, " timeout"}, 32'(cycles), 32'd34);
        end else if (exp_q.size() == 0) begin
            check({name, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            check({name, " result"}, result, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        bit          seen_done;

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC};
        vecs[7]  = '{3'b101, 32'd123,      32'd0,        32'hFFFFFFFF};
        vecs[8]  = '{3'b111, 32'd123,      32'd0,        32'd123};
        vecs[9]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[10] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[11] = '{3'b110, 32'd100,      32'hFFFFFFF9, 32'd2};

        rst = 1'b1; start = 1'b0; funct3 = 3'b000; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            start_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_done($sformatf("vec%0d", i), 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done_width", i), {31'b0, done}, 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom;
            if (i == 6) rb = 32'd0;
            rf = 3'(i);
            start_op(rf, ra, rb, model(rf, ra, rb));
            wait_done($sformatf("rand%0d", i), 0);
        end

        // Mid-CALC start ignored, then back-to-back MUL accepted in the done cycle.
        @(posedge clk);
        #1;
        start_op(3'b100, 32'd100, 32'd7, 32'd14);
        wait_done("div_ignore", 6);
        start_op(3'b000, 32'd6, 32'd7, 32'd42);
        check("b2b done_drop", {31'b0, done}, 32'd0);
        check("b2b busy_rise", {31'b0, busy}, 32'd1);
        check("b2b held", result, 32'd14);
        wait_done("b2b_mul", 0);

        // Reset abort 10 cycles into a divide.
        @(posedge clk);
        #1;
        start_op(3'b101, 32'd1000, 32'd3, 32'd333);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort result", result, 32'd0);
        exp_q.delete();
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1;
        end
        check("abort no_done", {31'b0, seen_done}, 32'd0);
        start_op(3'b011, 32'h00010000, 32'h00010000, 32'd1);
        wait_done("after_reset", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the RISC-V core. It sits beside the combinational ALU in the execute stage and handles the eight M-extension operations, which the ALU does not implement. Operands and funct3 are captured on a start handshake. The result is presented with a one-cycle done pulse after a fixed latency, and the core stalls on busy.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; accepted only when state is IDLE or DONE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  32  operand A / dividend.
- rs2_data  input  32  operand B / divisor.
- busy  output  1  high in CALC and FIXUP.
- done  output  1  high for exactly one cycle in DONE; result valid in that cycle.
- result  output  32  registered result; holds its value until the next done.

## Operation
- States:
  - IDLE: start → CALC, latch funct3 and operands, counter = 0.
  - CALC: counter increments each cycle; at counter == 31 → FIXUP.
  - FIXUP → DONE.
  - DONE: start → CALC (back-to-back accepted); else → IDLE.
- Operands are latched at acceptance. Later changes on rs1_data, rs2_data and funct3 have no effect.
- Magnitudes:
  - Signed ops (MULH, DIV, REM) use the absolute value of both operands.
  - MULHSU uses the absolute value of rs1 only.
  - Unsigned ops use the raw values.
  - Result sign is recorded at acceptance.
- Multiply:
  - 32-step shift-add on magnitudes into a 64-bit product.
  - FIXUP negates the 64-bit product if the sign flag is set.
  - MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - 32-step restoring division on magnitudes, giving quotient and remainder.
  - FIXUP: quotient is negated if the operand signs differ (signed ops). Remainder takes the sign of the dividend.
  - Truncation is toward zero.
- Special cases are resolved in FIXUP with the same fixed latency:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- result is written only on the FIXUP→DONE transition.
- start in CALC or FIXUP is ignored. It is not queued and is not an error.

## Timing
- Reset: state IDLE, busy 0, done 0, result 0x00000000, counter 0. Internal registers are cleared.
- start sampled high at edge N while in IDLE/DONE:
  - busy = 1 from after edge N through the cycle after edge N+32.
  - done = 1 and result valid in the cycle after edge N+33; busy = 0 in that cycle.
- Latency is 34 cycles from the start edge to the done cycle, for all eight ops including special cases.
- Back-to-back: start high during the done cycle is accepted at that edge. done drops and busy rises the next cycle. The previous result is held until the new done.
- rst high at any edge overrides start and any in-flight operation. The output takes reset values in the next cycle and the aborted result is never produced.
- done and busy are never high simultaneously.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → result 0xFFFFFFEB. done occurs exactly 34 cycles after start; busy is high for 33 cycles beforehand.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Special cases:
  - DIVU 123 / 0 → 0xFFFFFFFF; REMU 123 % 0 → 123.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - Each still takes 34 cycles.
- Start DIV 100/7, then pulse start with new operands mid-CALC → ignored; result = 14 at the original done time. Start a MUL in the done cycle → accepted; 14 is held until the next done.
- rst asserted 10 cycles into an operation → next cycle busy 0, done 0, result 0. No done pulse follows. A fresh start afterwards completes normally.
